// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse scheduler.
package pulse_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r++;
      end
      return r;
   endfunction

   // Channel index width, never narrower than one bit.
   function automatic int sel_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/pulse_scheduler_rr_pick.sv
// Combinational winner picker for the pulse scheduler.
// Default: round-robin, scanning upward from the channel after 'last'.
// With PULSE_SCHED_FIXED_PRIO_EN defined: lowest set index wins and the
// 'last' input does not exist.
module rr_pick
   import pulse_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int SEL_W = sel_width(N_REQ)
) (
   input  logic [N_REQ-1:0] pending,
`ifndef PULSE_SCHED_FIXED_PRIO_EN
   input  logic [SEL_W-1:0] last,
`endif
   output logic [SEL_W-1:0] winner,
   output logic             valid
);

`ifdef PULSE_SCHED_FIXED_PRIO_EN
   // Lowest pending index wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!valid && pending[i]) begin
            valid  = 1'b1;
            winner = SEL_W'(i);
         end
      end
   end
`else
   // First pending bit at last+1, last+2, ... modulo N_REQ.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      valid  = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = (int'(last) + i) % N_REQ;
         if (!valid && pending[idx]) begin
            valid  = 1'b1;
            winner = SEL_W'(idx);
         end
      end
   end
`endif

endmodule

// File: rtl/pulse_scheduler.sv
// Shared timed-pulse scheduler: latches requests as sticky pending bits,
// grants one channel at a time, drives a PULSE_WIDTH-cycle pulse tagged with
// the channel index, then holds the line low for GAP_CYCLES plus one
// arbitration cycle so consecutive strobes never merge.
// Build option: PULSE_SCHED_FIXED_PRIO_EN selects fixed priority (lowest
// index wins) instead of round-robin.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | line low, arbitrating among pending channels
// ST_PULSE | pulse high, count runs 1..PULSE_WIDTH
// ST_GAP   | enforced low gap, count runs 1..GAP_CYCLES
module pulse_scheduler
   import pulse_sched_pkg::*;
#(
   parameter  int N_REQ       = 4,
   parameter  int PULSE_WIDTH = 1,
   parameter  int GAP_CYCLES  = 1,
   parameter  int CNT_W       = 32,
   localparam int SEL_W       = sel_width(N_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   output logic             pulse,
   output logic [SEL_W-1:0] pulse_sel,
   output logic             done,
   output logic             busy,
   output logic [N_REQ-1:0] pending
);

   state_e             state, state_nxt;
   logic [CNT_W-1:0]   count, count_nxt;
   logic               pulse_nxt;
   logic               done_nxt;
   logic [SEL_W-1:0]   sel_nxt;
   logic [N_REQ-1:0]   pending_nxt;
   logic [N_REQ-1:0]   grant_mask;
   logic [SEL_W-1:0]   winner;
   logic               pick_valid;
`ifndef PULSE_SCHED_FIXED_PRIO_EN
   logic [SEL_W-1:0]   last, last_nxt;
`endif

   rr_pick #(
      .N_REQ (N_REQ),
      .SEL_W (SEL_W)
   ) u_pick (
      .pending (pending),
`ifndef PULSE_SCHED_FIXED_PRIO_EN
      .last    (last),
`endif
      .winner  (winner),
      .valid   (pick_valid)
   );

   // Next-state, counter, output and pending-update logic.
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      pulse_nxt  = pulse;
      done_nxt   = 1'b0;
      sel_nxt    = pulse_sel;
      grant_mask = '0;
`ifndef PULSE_SCHED_FIXED_PRIO_EN
      last_nxt   = last;
`endif
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_nxt  = ST_PULSE;
               pulse_nxt  = 1'b1;
               sel_nxt    = winner;
               count_nxt  = CNT_W'(1);
               grant_mask = N_REQ'(1) << winner;
`ifndef PULSE_SCHED_FIXED_PRIO_EN
               last_nxt   = winner;
`endif
            end
         end
         ST_PULSE: begin
            if (count == CNT_W'(PULSE_WIDTH)) begin
               pulse_nxt = 1'b0;
               done_nxt  = 1'b1;
               count_nxt = CNT_W'(1);
               state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else begin
               count_nxt = count + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (count == CNT_W'(GAP_CYCLES)) begin
               state_nxt = ST_IDLE;
            end else begin
               count_nxt = count + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            pulse_nxt = 1'b0;
         end
      endcase
      // A request arriving on the channel being granted re-arms it.
      pending_nxt = (pending & ~grant_mask) | req;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         count     <= '0;
         pulse     <= 1'b0;
         done      <= 1'b0;
         pulse_sel <= '0;
         pending   <= '0;
`ifndef PULSE_SCHED_FIXED_PRIO_EN
         last      <= SEL_W'(N_REQ - 1);
`endif
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         pulse     <= pulse_nxt;
         done      <= done_nxt;
         pulse_sel <= sel_nxt;
         pending   <= pending_nxt;
`ifndef PULSE_SCHED_FIXED_PRIO_EN
         last      <= last_nxt;
`endif
      end
   end

   // Busy whenever the line is owned (pulse or enforced gap).
   always_comb begin
      busy = (state == ST_PULSE) || (state == ST_GAP);
   end

endmodule
